// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle 16x16 unsigned multiply / divide sequencer.
// It borrows the shared execute-stage ALU for one add or subtract per cycle.
// MULT uses shift-and-add. DIVU uses restoring shift-and-subtract.
// Results are left in the hi/lo registers.
module alu_muldiv_seq #(
  parameter int         WIDTH  = 16,
  parameter logic [2:0] OP_ADD = 3'b010,
  parameter logic [2:0] OP_SUB = 3'b110
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [2:0]       alu_opcode,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;     // multiplier M or divisor D, latched on accept
  logic             op_q, op_d;   // 0 = MULT, 1 = DIVU
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // Next-state and datapath: accept, one iteration per RUN cycle, single-cycle DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    op_d    = op_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op && (b == '0)) begin
            // Divide by zero: finish immediately with a recognisable result.
            hi_d    = a;
            lo_d    = '1;
            dz_d    = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            m_d     = b;
            op_d    = op;
            hi_d    = '0;
            lo_d    = a;
            cnt_d   = '0;
            dz_d    = 1'b0;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!op_q) begin
          // The carry out of the add becomes the new top bit of hi.
          hi_d = {alu_cout, alu_out[WIDTH-1:1]};
          lo_d = {alu_out[0], lo_q[WIDTH-1:1]};
        end else if (hi_q[WIDTH-1] || alu_cout) begin
          // The shifted remainder is at least D. A set hi[15] means it overflowed 16 bits.
          hi_d = alu_out;
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ALU drive is combinational from state. The ALU idles with zero operands outside RUN.
  always_comb begin
    alu_x      = '0;
    alu_y      = '0;
    alu_opcode = OP_ADD;
    alu_cin    = 1'b0;
    if (state_q == S_RUN) begin
      if (!op_q) begin
        alu_x = hi_q;
        alu_y = lo_q[0] ? m_q : '0;
      end else begin
        alu_x      = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        alu_y      = m_q;
        alu_opcode = OP_SUB;
      end
    end
  end

  // State and result registers. Reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      op_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Testbench for alu_muldiv_seq. It includes a behavioural model of the shared 16-bit ALU.
// Expected results go into a queue when an operation is accepted.
// They are taken back out and compared when done is seen.
module tb_alu_muldiv_seq;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, div_zero, alu_cin, alu_cout;
  logic [15:0] hi, lo, alu_x, alu_y, alu_out;
  logic [2:0]  alu_opcode;
  logic [16:0] alu_sum;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] eh;
    logic [15:0] el;
    logic        edz;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] eh;
    logic [15:0] el;
    logic        edz;
  } vec_t;

  alu_muldiv_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
    .alu_x(alu_x), .alu_y(alu_y), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // Shared ALU model. For subtract, cout = 1 means there was no borrow.
  assign alu_sum  = (alu_opcode == OP_SUB) ? ({1'b0, alu_x} + {1'b0, ~alu_y} + 17'd1)
                                           : ({1'b0, alu_x} + {1'b0, alu_y} + {16'd0, alu_cin});
  assign alu_out  = alu_sum[15:0];
  assign alu_cout = alu_sum[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Run one operation and check latency, busy, result and hold-after-done.
  // glitch >= 1 pulses start with other operands during that RUN cycle.
  task automatic do_op(input logic op_i, input logic [15:0] a_i, input logic [15:0] b_i,
                       input logic [15:0] eh, input logic [15:0] el, input logic edz,
                       input int glitch);
    sb_t e;
    sb_t got;
    int  cycles;
    logic busy_seen;
    @(negedge clk);
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    e.eh = eh; e.el = el; e.edz = edz;
    sb_q.push_back(e);
    @(negedge clk);
    // Scramble the inputs while the operation runs. They must have no effect.
    start = 1'b0; op = ~op_i; a = ~a_i; b = b_i + 16'd1;
    cycles = 1;
    busy_seen = busy;
    while (!done && cycles < 40) begin
      start = (cycles == glitch);
      @(negedge clk);
      cycles++;
      busy_seen |= busy;
    end
    start = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    check("latency", 32'(cycles), edz ? 32'd1 : 32'd17);
    check("busy_seen", {31'd0, busy_seen}, {31'd0, ~edz});
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      got = e;
    end else begin
      got = sb_q.pop_front();
    end
    check("hi", {16'd0, hi}, {16'd0, got.eh});
    check("lo", {16'd0, lo}, {16'd0, got.el});
    check("div_zero", {31'd0, div_zero}, {31'd0, got.edz});
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d (exp hi=%h lo=%h dz=%0d)",
             op_i, a_i, b_i, hi, lo, div_zero, cycles, got.eh, got.el, got.edz);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("hold_hi", {16'd0, hi}, {16'd0, got.eh});
    check("hold_lo", {16'd0, lo}, {16'd0, got.el});
  endtask

  vec_t vecs[10];

  initial begin
    int   extra;
    logic [31:0] p;
    logic        rop;
    logic [15:0] ra, rb;

    vecs[0] = '{1'b0, 16'd3,    16'd5,    16'h0000, 16'h000F, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0};
    vecs[2] = '{1'b1, 16'd100,  16'd7,    16'd2,    16'd14,   1'b0};
    vecs[3] = '{1'b1, 16'hFFFF, 16'd1,    16'h0000, 16'hFFFF, 1'b0};
    vecs[4] = '{1'b1, 16'h1234, 16'd0,    16'h1234, 16'hFFFF, 1'b1};
    vecs[5] = '{1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0};
    vecs[6] = '{1'b1, 16'd5,    16'd9,    16'd5,    16'd0,    1'b0};
    vecs[7] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0};
    vecs[8] = '{1'b0, 16'h8000, 16'd2,    16'h0001, 16'h0000, 1'b0};
    vecs[9] = '{1'b1, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    check("rst_hi", {16'd0, hi}, 32'd0);
    check("rst_lo", {16'd0, lo}, 32'd0);
    check("rst_opcode", {29'd0, alu_opcode}, {29'd0, OP_ADD});
    reset_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 10; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].edz, -1);

    // Random vectors with reference arithmetic
    for (int i = 0; i < 8; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = 16'($urandom);
      rb  = (i == 3) ? 16'd0 : 16'($urandom);
      if (!rop) begin
        p = 32'(ra) * 32'(rb);
        do_op(rop, ra, rb, p[31:16], p[15:0], 1'b0, -1);
      end else if (rb == 16'd0) begin
        do_op(rop, ra, rb, ra, 16'hFFFF, 1'b1, -1);
      end else begin
        do_op(rop, ra, rb, ra % rb, ra / rb, 1'b0, -1);
      end
    end

    // A start pulse during RUN cycle 5 is ignored and produces exactly one done.
    do_op(1'b0, 16'h1234, 16'h0056, 16'h0006, 16'h1D78, 1'b0, 5);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("no_extra_op", 32'(extra), 32'd0);

    // An asynchronous reset mid-RUN aborts the operation.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'h00FF; b = 16'h0101;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_dz", {31'd0, div_zero}, 32'd0);
    check("arst_hi", {16'd0, hi}, 32'd0);
    check("arst_lo", {16'd0, lo}, 32'd0);
    check("arst_alu_x", {16'd0, alu_x}, 32'd0);
    check("arst_alu_y", {16'd0, alu_y}, 32'd0);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) extra++;
    end
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("abort_no_done", 32'(extra), 32'd0);
    do_op(1'b0, 16'd2, 16'd2, 16'd0, 16'd4, 1'b0, -1);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
